alu_seq: RTL and testbench
==========================

# alu_seq

Instruction sequencer that drives the 8-bit accumulator ALU from the initiator side. It accepts one instruction at a time over a valid/ready handshake and presents operands and opcode to the ALU. It captures the ALU's registered result into the architectural accumulator and signals completion. Conditional instructions use the ALU's zero flag to skip execution when the accumulator is zero.

## Interface
- `WIDTH`, 8: datapath width; fixed to 8 to match the ALU.
- `CNT_W`, 8: width of the executed-instruction counter.
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `instr_valid` in 1: instruction present on `instr`.
- `instr_ready` out 1: sequencer can accept an instruction this cycle.
- `instr` in 12: instruction word. `[11]` is cond. `[10:8]` is opcode. `[7:0]` is the data operand.
- `alu_accum` out 8: accumulator operand to the ALU.
- `alu_data` out 8: data operand to the ALU.
- `alu_opcode` out 3: opcode to the ALU.
- `alu_out` in 8: ALU registered result.
- `alu_zero` in 1: ALU zero flag, high when `alu_accum == 0`.
- `acc_out` out 8: architectural accumulator.
- `done` out 1: one-cycle pulse when an instruction retires.
- `skipped` out 1: valid with `done`; high if the retiring instruction was skipped.
- `instr_count` out CNT_W: count of executed (non-skipped) instructions.

## Operation
- Opcodes pass through uninterpreted:
  - 000 pass accum
  - 001 saturating signed add
  - 010 subtract
  - 011 AND
  - 100 XOR
  - 101 abs
  - 110 4-bit signed multiply
  - 111 load data
- `alu_accum` is always driven from the accumulator register `acc_r`, so `acc_out == alu_accum`.
- State machine states: IDLE, ISSUE, CAPTURE.
- **IDLE**
  - `instr_ready` = 1.
  - Handshake when `instr_valid && instr_ready` at a rising edge.
  - If cond = 1 and `alu_zero` = 1: the instruction is skipped. Pulse `done` = 1 and `skipped` = 1 next cycle. `acc_r` and `instr_count` are unchanged. Stay in IDLE.
  - Otherwise: latch opcode into `op_r` and data into `data_r`, then go to ISSUE.
- **ISSUE**
  - `instr_ready` = 0.
  - `alu_opcode` = `op_r`, `alu_data` = `data_r`, held stable for the whole cycle.
  - The ALU registers its result at the end of this cycle. Go to CAPTURE.
- **CAPTURE**
  - `instr_ready` = 0; ALU inputs still held.
  - At the edge: `acc_r` <= `alu_out`, `instr_count` <= `instr_count` + 1 (wraps modulo 2^CNT_W), `done` <= 1, `skipped` <= 0. Go to IDLE.
- `instr_valid` while `instr_ready` = 0 is ignored. The initiator holds `instr` and `instr_valid` until the handshake.
- `alu_opcode` and `alu_data` hold their last value while in IDLE, avoiding spurious toggling.
- Outputs `done` and `skipped` are registered; never combinational from `instr_valid`.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE
  - `acc_r` = 0, `op_r` = 000, `data_r` = 0
  - `instr_count` = 0
  - `done` = 0, `skipped` = 0
  - `instr_ready` = 1 once reset is low
- Reset asserted mid-ISSUE or mid-CAPTURE aborts the instruction: no `done`, `acc_r` = 0, count unchanged from 0.
- Executed instruction, handshake at edge N:
  - cycle N+1: ISSUE
  - cycle N+2: CAPTURE, `alu_out` valid
  - cycle N+3: `done` = 1, `acc_out` holds the new value, `instr_ready` = 1
  - Throughput is one instruction per 3 cycles; the next handshake is possible at edge N+3.
- Skipped instruction, handshake at edge N:
  - cycle N+1: `done` = 1, `skipped` = 1, `instr_ready` = 1
  - Back-to-back skips retire one per cycle.
- The `alu_zero` sample for cond uses the accumulator value at the handshake edge, which includes a result written at the previous edge.
- `done` is never high for two consecutive cycles from the same instruction.

## Test plan
- **Load, then add.** Load with `instr` = 0x7_05 (op 111, data 0x05), handshake at edge N.
  - `done` at N+3 with `acc_out` = 0x05, `instr_count` = 1.
  - Then add with op 001, data 0x03: `acc_out` = 0x08, `instr_count` = 2.
- **Saturation.** Load 0x70, then op 001 with data 0x20: `acc_out` = 0x7F.
  - Load 0x90, then op 001 with data 0x90: `acc_out` = 0x80.
- **Conditional skip.** With `acc_out` = 0x08, apply XOR (op 100) with data 0x08 → `acc_out` = 0x00.
  - Then cond add 0x01 (`instr` = 0x9_01): `done` and `skipped` high one cycle after the handshake; `acc_out` = 0x00; count unchanged.
  - Then cond add with `acc_out` nonzero: executes normally, `skipped` = 0.
- **Back-to-back and stall.** Hold `instr_valid` high across two instructions.
  - Second handshake occurs exactly 3 cycles after the first; `instr_ready` = 0 during ISSUE and CAPTURE.
  - `instr` changes while `instr_ready` = 0 are ignored.
- **Reset mid-operation.** Assert `reset` during CAPTURE of an add.
  - Immediately: `acc_out` = 0, `done` = 0, `instr_count` = 0, `instr_ready` = 1 after release.
  - No late `done` pulse.
- **Counter wrap.** Execute 256 op-000 instructions: `instr_count` returns to 0x00; `acc_out` is unchanged throughout.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: instruction sequencer for the 8-bit accumulator ALU.
// It takes one instruction per valid/ready handshake and drives the ALU operands.
// It writes the registered ALU result back into the architectural accumulator.
// A conditional instruction is retired as skipped when the accumulator is zero.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [11:0]      instr,
  output logic [WIDTH-1:0] alu_accum,
  output logic [WIDTH-1:0] alu_data,
  output logic [2:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] acc_out,
  output logic             done,
  output logic             skipped,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             skipped_q, skipped_d;

  // Next-state and next-register values for the IDLE/ISSUE/CAPTURE sequence.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    skipped_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          if (instr[11] && alu_zero) begin
            // Conditional instruction on a zero accumulator: retire without executing.
            done_d    = 1'b1;
            skipped_d = 1'b1;
          end else begin
            op_d    = instr[10:8];
            data_d  = instr[WIDTH-1:0];
            state_d = ISSUE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        // The ALU registers its result at the end of this cycle.
        state_d = CAPTURE;
      end
      CAPTURE: begin
        acc_d   = alu_out;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= {WIDTH{1'b0}};
      op_q      <= 3'b000;
      data_q    <= {WIDTH{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      done_q    <= 1'b0;
      skipped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      op_q      <= op_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      skipped_q <= skipped_d;
    end
  end

  // Ready is a pure decode of the state register, so it never depends on instr_valid.
  assign instr_ready = (state_q == IDLE);
  // ALU operands come straight from registers, so they hold their value while idle.
  assign alu_accum   = acc_q;
  assign alu_data    = data_q;
  assign alu_opcode  = op_q;
  assign acc_out     = acc_q;
  assign done        = done_q;
  assign skipped     = skipped_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq with a behavioural registered ALU attached.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [11:0] instr;
  logic [7:0]  alu_accum;
  logic [7:0]  alu_data;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_out = 8'h00;
  logic        alu_zero;
  logic [7:0]  acc_out;
  logic        done;
  logic        skipped;
  logic [7:0]  instr_count;

  int checks = 0;
  int errors = 0;

  alu_seq #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_accum(alu_accum), .alu_data(alu_data), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_zero(alu_zero), .acc_out(acc_out), .done(done),
    .skipped(skipped), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: combinational function, registered result.
  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    logic [7:0] s;
    logic [3:0] a4;
    logic [3:0] d4;
    logic signed [7:0] p;
    s  = a + d;
    a4 = a[3:0];
    d4 = d[3:0];
    p  = 8'(signed'(a4) * signed'(d4));
    case (op)
      3'd0: alu_f = a;
      3'd1: begin
        if (a[7] == d[7] && s[7] != a[7]) alu_f = a[7] ? 8'h80 : 8'h7F;
        else alu_f = s;
      end
      3'd2: alu_f = a - d;
      3'd3: alu_f = a & d;
      3'd4: alu_f = a ^ d;
      3'd5: alu_f = a[7] ? (8'h00 - a) : a;
      3'd6: alu_f = p;
      default: alu_f = d;
    endcase
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_opcode, alu_accum, alu_data);
  assign alu_zero = (alu_accum == 8'h00);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one instruction from IDLE and check latency, flags and results at retirement.
  task automatic run_instr(input string tag, input logic [11:0] ins, input logic exp_skip,
                           input logic [7:0] exp_acc, input logic [7:0] exp_cnt);
    int lat;
    lat = 0;
    instr_valid = 1'b1;
    instr       = ins;
    check_eq({tag, " ready"}, 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_eq({tag, " latency"}, 32'(lat), exp_skip ? 32'd1 : 32'd3);
    check_eq({tag, " skipped"}, 32'(skipped), 32'(exp_skip));
    check_eq({tag, " acc"}, 32'(acc_out), 32'(exp_acc));
    check_eq({tag, " count"}, 32'(instr_count), 32'(exp_cnt));
    @(negedge clk);
    check_eq({tag, " done single"}, 32'(done), 32'd0);
  endtask

  initial begin
    int seen_done;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 12'h000;
    repeat (3) @(negedge clk);
    check_eq("rst acc", 32'(acc_out), 32'h00);
    check_eq("rst cnt", 32'(instr_count), 32'h00);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst skipped", 32'(skipped), 32'd0);
    check_eq("rst op", 32'(alu_opcode), 32'd0);
    check_eq("rst data", 32'(alu_data), 32'h00);
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst ready", 32'(instr_ready), 32'd1);

    // Directed sequence with hand-computed results.
    run_instr("load5",   12'h705, 1'b0, 8'h05, 8'd1);
    run_instr("add3",    12'h103, 1'b0, 8'h08, 8'd2);
    run_instr("xor8",    12'h408, 1'b0, 8'h00, 8'd3);
    run_instr("cskip1",  12'h901, 1'b1, 8'h00, 8'd3);
    run_instr("cskip2",  12'h9FF, 1'b1, 8'h00, 8'd3);
    run_instr("load70",  12'h770, 1'b0, 8'h70, 8'd4);
    run_instr("cadd20",  12'h920, 1'b0, 8'h7F, 8'd5);
    run_instr("load90",  12'h790, 1'b0, 8'h90, 8'd6);
    run_instr("add90",   12'h190, 1'b0, 8'h80, 8'd7);
    run_instr("sub5",    12'h205, 1'b0, 8'h7B, 8'd8);
    run_instr("and0f",   12'h30F, 1'b0, 8'h0B, 8'd9);
    run_instr("loadf6",  12'h7F6, 1'b0, 8'hF6, 8'd10);
    run_instr("abs",     12'h500, 1'b0, 8'h0A, 8'd11);
    run_instr("load3",   12'h703, 1'b0, 8'h03, 8'd12);
    run_instr("mul",     12'h6FE, 1'b0, 8'hFA, 8'd13);
    run_instr("pass",    12'h000, 1'b0, 8'hFA, 8'd14);

    // Back-to-back with valid held high and instr changed while not ready.
    instr_valid = 1'b1;
    instr       = 12'h701;
    @(posedge clk);
    #1 instr = 12'h7FF;
    @(negedge clk);
    check_eq("b2b issue ready", 32'(instr_ready), 32'd0);
    @(negedge clk);
    check_eq("b2b capture ready", 32'(instr_ready), 32'd0);
    instr = 12'h102;
    @(negedge clk);
    check_eq("b2b done1", 32'(done), 32'd1);
    check_eq("b2b acc1", 32'(acc_out), 32'h01);
    check_eq("b2b ready again", 32'(instr_ready), 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b issue2 ready", 32'(instr_ready), 32'd0);
    check_eq("b2b done low", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("b2b done2", 32'(done), 32'd1);
    check_eq("b2b acc2", 32'(acc_out), 32'h03);
    check_eq("b2b cnt2", 32'(instr_count), 32'd16);
    @(negedge clk);

    // Reset during CAPTURE of an add.
    instr_valid = 1'b1;
    instr       = 12'h105;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("midrst acc", 32'(acc_out), 32'h00);
    check_eq("midrst done", 32'(done), 32'd0);
    check_eq("midrst cnt", 32'(instr_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst ready", 32'(instr_ready), 32'd1);
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done = 1;
    end
    check_eq("midrst late done", 32'(seen_done), 32'd0);
    check_eq("midrst acc hold", 32'(acc_out), 32'h00);

    // Counter wrap: load, then 255 pass instructions bring the count back to 0.
    run_instr("wrap load", 12'h7A5, 1'b0, 8'hA5, 8'd1);
    for (int i = 0; i < 255; i++) begin
      run_instr("wrap pass", 12'h000, 1'b0, 8'hA5, 8'((i + 2) & 255));
    end
    check_eq("wrap final cnt", 32'(instr_count), 32'h00);
    check_eq("wrap final acc", 32'(acc_out), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
